// File: rtl/key_sweep_checker.sv
// key_sweep_checker
//   Purpose : On-board replacement for the lab stimulus bench. It walks the
//             key bus through every value in ascending order and holds each
//             value for DWELL cycles. SETTLE cycles after each key change it
//             compares led against exp_led. It then reports pass/fail, the
//             number of mismatching keys, and the first failing key and led.
//   Ports   : clk, rst (synchronous, active-high), start (level request);
//             key -> module under test; led <- module under test;
//             exp_led <- external expected-value table (combinational on key);
//             busy, done, pass, err_cnt, fail_key, fail_led -> result flags.
//   Option  : KEY_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module key_sweep_checker #(
  parameter int KEY_W  = 2,
  parameter int LED_W  = 10,
  parameter int DWELL  = 10,   // must be >= SETTLE + 2
  parameter int SETTLE = 2     // must be >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [KEY_W-1:0] key,
  input  logic [LED_W-1:0] led,
  input  logic [LED_W-1:0] exp_led,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [KEY_W:0]   err_cnt,
  output logic [KEY_W-1:0] fail_key,
  output logic [LED_W-1:0] fail_led
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam int ERR_W = KEY_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DWELL,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;        // cycles since the current key value appeared
  logic             launch;     // begin a new sweep at key 0
  logic             advance;    // move on to the next key value
  logic             mismatch;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    advance   = 1'b0;
    mismatch  = (led != exp_led);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
          launch    = 1'b1;
        end
      end
      ST_SETTLE: begin
        // cnt == SETTLE-1 here puts CHECK exactly SETTLE cycles after the key change
        if (cnt == CNT_W'(SETTLE - 1)) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
`ifdef KEY_SWEEP_STOP_ON_FAIL_EN
        state_nxt = mismatch ? ST_DONE : ST_DWELL;
`else
        state_nxt = ST_DWELL;
`endif
      end
      ST_DWELL: begin
        // The last cycle of the step is cnt == DWELL-1, so every step lasts DWELL cycles
        if (cnt == CNT_W'(DWELL - 1)) begin
          if (&key) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_SETTLE;
            advance   = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      key      <= '0;
      cnt      <= '0;
      err_cnt  <= '0;
      fail_key <= '0;
      fail_led <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        key      <= '0;
        cnt      <= '0;
        err_cnt  <= '0;
        fail_key <= '0;
        fail_led <= '0;
      end else if (advance) begin
        key <= key + KEY_W'(1);
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt + CNT_W'(1);
      end
      // CHECK never coincides with launch, so the result clear above cannot collide
      if (state == ST_CHECK && mismatch) begin
        err_cnt <= err_cnt + ERR_W'(1);
        if (err_cnt == '0) begin
          fail_key <= key;
          fail_led <= led;
        end
      end
    end
  end

  assign busy = (state == ST_SETTLE) || (state == ST_CHECK) || (state == ST_DWELL);
  assign done = (state == ST_DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_key_sweep_checker.sv
// Bench for key_sweep_checker: drives led from a reference table, with an
// optional forced fault on one key and an optional settle-window glitch, and
// checks the key sequence cycle by cycle plus the sweep results.
module tb_key_sweep_checker;

  localparam int KEY_W  = 2;
  localparam int LED_W  = 10;
  localparam int DWELL  = 10;
  localparam int SETTLE = 2;
  localparam int NKEY   = 1 << KEY_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [KEY_W-1:0] key;
  logic [LED_W-1:0] led;
  logic [LED_W-1:0] exp_led;
  logic             busy, done, pass;
  logic [KEY_W:0]   err_cnt;
  logic [KEY_W-1:0] fail_key;
  logic [LED_W-1:0] fail_led;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  bit               fault_en  = 1'b0;
  bit               glitch_en = 1'b0;
  logic [KEY_W-1:0] fault_key = '0;

  typedef struct {
    logic [KEY_W:0]   err;
    logic [KEY_W-1:0] fkey;
    logic [LED_W-1:0] fled;
    logic             pass;
    logic [KEY_W-1:0] last;
    int               len;
  } res_t;

  res_t sb[$];

  key_sweep_checker #(
    .KEY_W(KEY_W), .LED_W(LED_W), .DWELL(DWELL), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .led(led), .exp_led(exp_led),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_key(fail_key), .fail_led(fail_led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LED_W-1:0] tbl(input logic [KEY_W-1:0] k);
    case (k)
      2'd0:    return 10'h015;
      2'd1:    return 10'h0AA;
      2'd2:    return 10'h155;
      default: return 10'h2C3;
    endcase
  endfunction

  // led seen by the checker for key k, age cycles into the step
  function automatic logic [LED_W-1:0] led_model(input logic [KEY_W-1:0] k, input int age,
                                                 input bit f, input bit g,
                                                 input logic [KEY_W-1:0] fk);
    if (f && k == fk) return 10'h3FF;
    if (g && age == 1) return ~tbl(k);
    return tbl(k);
  endfunction

  assign exp_led = tbl(key);
  always_comb led = led_model(key, (cyc - t0) % DWELL, fault_en, glitch_en, fault_key);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic res_t predict();
    res_t r;
    r.err  = '0;
    r.fkey = '0;
    r.fled = '0;
    r.last = KEY_W'(NKEY - 1);
    r.len  = NKEY * DWELL;
    for (int k = 0; k < NKEY; k++) begin
      logic [LED_W-1:0] l;
      l = led_model(k[KEY_W-1:0], SETTLE, fault_en, glitch_en, fault_key);
      if (l != tbl(k[KEY_W-1:0])) begin
        if (r.err == 0) begin
          r.fkey = k[KEY_W-1:0];
          r.fled = l;
        end
        r.err = r.err + 1'b1;
`ifdef KEY_SWEEP_STOP_ON_FAIL_EN
        r.len  = k * DWELL + SETTLE + 1;
        r.last = k[KEY_W-1:0];
        break;
`endif
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  // Pulse start for one edge; afterwards we sit in the first cycle of key 0.
  task automatic start_sweep();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    sb.push_back(predict());
  endtask

  // Full sweep; poke_at >= 0 re-pulses start at that offset (should be ignored).
  task automatic run_sweep(input int poke_at);
    res_t e;
    int   len;
    start_sweep();
    len = sb[sb.size()-1].len;
    for (int o = 0; o < len; o++) begin
      chk("step", {key, busy, done}, {KEY_W'(o / DWELL), 1'b1, 1'b0});
      if (o == 0) chk("cleared", {err_cnt, fail_key, fail_led}, 64'd0);
      start = (o == poke_at);
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("done", {busy, done, pass, key}, {1'b0, 1'b1, e.pass, e.last});
    chk("err_cnt", err_cnt, e.err);
    chk("fail_key", fail_key, e.fkey);
    chk("fail_led", fail_led, e.fled);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", {key, busy, done, pass, err_cnt, fail_key, fail_led}, 64'd0);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    chk("idle", {key, busy, done, pass}, 64'd0);

    // clean sweep
    run_sweep(-1);
    // settle-window glitch plus an ignored mid-sweep start
    glitch_en = 1'b1;
    run_sweep(15);
    glitch_en = 1'b0;
    // single fault on key 2, start poked on the last busy cycle
    fault_en  = 1'b1;
    fault_key = 2'd2;
    run_sweep(sb.size() == 0 ? (fault_en ? predict().len - 1 : -1) : -1);
    fault_en  = 1'b0;
    // restart directly from DONE: results must clear
    run_sweep(-1);

    // reset mid-sweep while key = 01
    start_sweep();
    repeat (12) @(negedge clk);
    chk("mid_key", key, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", {key, busy, done, err_cnt}, 64'd0);
    rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("mid_idle", {busy, done}, 64'd0);

    // fresh sweep after the abort, with a fault to confirm results
    fault_en  = 1'b1;
    fault_key = 2'd3;
    run_sweep(-1);
    fault_en  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_sweep_checker.md
# key_sweep_checker

Synthesizable counterpart of the lab stimulus bench: it drives every value of the board `key` bus into a lab module in ascending order and holds each value for a fixed dwell. After a settle interval it samples the module's `led` response against an expected pattern, then reports pass/fail, an error count and the first failing vector. It sits on the board in place of the simulation-only bench, between the push-button inputs and the lab module under test.

## Interface

- `KEY_W`, 2, width of the key bus driven to the module under test
- `LED_W`, 10, width of the led bus read back
- `DWELL`, 10, cycles each key value is held; legal range `DWELL >= SETTLE + 2`
- `SETTLE`, 2, cycles after a key change before led is sampled; `>= 1`

Ports:

- `clk` input 1, single clock; every register is clocked on its rising edge
- `rst` input 1, synchronous, active-high reset
- `start` input 1, level-sampled request to begin a sweep
- `key` output KEY_W, stimulus to the module under test
- `led` input LED_W, response from the module under test
- `exp_led` input LED_W, expected led for the current `key`, supplied combinationally by an external table
- `busy` output 1, sweep in progress
- `done` output 1, sweep finished; results valid
- `pass` output 1, `done` with zero mismatches
- `err_cnt` output KEY_W+1, number of mismatching key values
- `fail_key` output KEY_W, key value of the first mismatch
- `fail_led` output LED_W, led value captured at the first mismatch

## Operation

- Reset values: `key`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_key`=0, `fail_led`=0; state IDLE.
- States: IDLE, SETTLE, CHECK, DWELL, DONE.
- **IDLE:** if `start`=1, go to SETTLE, with `key`=0, `busy`=1 and the results cleared.
- **SETTLE:** hold `key` for SETTLE cycles, then go to CHECK.
- **CHECK:** one cycle.
  - If `led != exp_led`, increment `err_cnt`.
  - If `err_cnt` was 0, also capture `fail_key`=`key` and `fail_led`=`led`.
  - Then go to DWELL.
- **DWELL:** hold `key` for the remaining cycles of the step.
  - If `key` is all-ones, go to DONE.
  - Otherwise go to SETTLE with `key`+1.
- **DONE:** `busy`=0, `done`=1, `pass`=(`err_cnt`==0). `key` holds its last value.
  - `start`=1 re-enters SETTLE with the same effects as from IDLE.
  - Outside DONE, `done` and `pass` are 0.
- `start` is ignored while `busy`=1. A `start` held high continuously produces back-to-back sweeps; each sweep runs to completion.
- `err_cnt` cannot overflow: its maximum is 2^KEY_W, which fits in KEY_W+1 bits.
- `led` is compared only in CHECK. Values of `led` in any other cycle have no effect.

## Timing

- Step start cycle s is the first cycle in which `key` shows a new value.
- `led` and `exp_led` are sampled in cycle s+SETTLE.
- The next key value appears in cycle s+DWELL. Every step is exactly DWELL cycles long.
- `start` seen at edge t gives `key`=0 and `busy`=1 in cycle t+1.
- A full sweep occupies 2^KEY_W × DWELL cycles. `done` rises in the first cycle after the last step ends.
- `err_cnt`, `fail_key` and `fail_led` update in cycle s+SETTLE+1.
- `rst` has priority over everything. Reset mid-sweep abandons the sweep; all outputs take their reset values in the next cycle.

## Configuration

- `KEY_SWEEP_STOP_ON_FAIL_EN`
  - Defined: a mismatch in CHECK goes directly to DONE instead of DWELL. `key` stays at the failing value, `err_cnt`=1, `done`=1 in cycle s+SETTLE+1.
  - Undefined: the sweep always covers all 2^KEY_W values and counts every mismatch.

## Test plan

- **Reset:** hold `rst`=1 for 3 cycles with `start`=1 → all outputs 0 throughout, state IDLE after release.
- **Clean sweep** (DWELL=10, SETTLE=2, bench `led` = `exp_led` table): one-cycle `start` pulse → `key` = 00, 01, 10, 11 for 10 cycles each; `done`=1 and `pass`=1 exactly 40 cycles after `key`=00 first appears; `err_cnt`=0.
- **Single fault:** force `led`=10'h3FF only while `key`=10 → `err_cnt`=1, `fail_key`=10, `fail_led`=3FF, `pass`=0. With `KEY_SWEEP_STOP_ON_FAIL_EN` defined: `done` at step start + 3, `key` stays at 10.
- **Settle window:** wrong `led` only in cycle s+1 of each step, correct at s+2 → `err_cnt`=0, `pass`=1.
- **Start handling:** pulse `start` mid-sweep → ignored, 40-cycle sweep unchanged. Pulse `start` in DONE after the fault sweep → `done` drops next cycle, `err_cnt` cleared, new sweep begins at `key`=00.
- **Reset mid-operation:** assert `rst` while `key`=01 → next cycle `key`=0 and `busy`=0. A later `start` yields a full fresh sweep with correct results.
